alu_exec_unit: RTL

//  Execute-stage consumer of the 3-bit ALUControl code from the ALU controller.

---
 rtl/alu_exec_unit.sv | 104 ++++++++++
 1 files changed

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: EX-stage ALU with valid/ready handshake and a 2-entry output skid buffer.
// Optional macro ALU_ERR_STICKY_EN adds errClr/errSticky, a sticky illegal-op flag.
module alu_exec_unit #(
    parameter int WIDTH = 32,
    parameter int RD_W  = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inValid,
    output logic             inReady,
    input  logic [2:0]       ALUControl,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    input  logic [RD_W-1:0]  rdIn,
    input  logic             flush,
`ifdef ALU_ERR_STICKY_EN
    input  logic             errClr,
    output logic             errSticky,
`endif
    output logic             outValid,
    input  logic             outReady,
    output logic [WIDTH-1:0] ALUResult,
    output logic             zero,
    output logic [RD_W-1:0]  rdOut,
    output logic             illegalOp
);
    typedef struct packed {
        logic [WIDTH-1:0] res;
        logic             z;
        logic [RD_W-1:0]  rd;
        logic             ill;
    } entry_t;

    logic [1:0]       count_q, count_d;
    entry_t           e0_q, e0_d, e1_q, e1_d, new_e;
    logic [WIDTH-1:0] res;
    logic             push, pop;

    always_comb begin
        case (ALUControl)
            3'b000:  res = srcA + srcB;
            3'b001:  res = srcA - srcB;
            3'b010:  res = srcA & srcB;
            3'b011:  res = srcA | srcB;
            3'b100:  res = srcA ^ srcB;
            3'b101:  res = {{(WIDTH-1){1'b0}}, $signed(srcA) < $signed(srcB)};
            default: res = '0;
        endcase
    end

    assign new_e    = '{res: res, z: (res == '0), rd: rdIn, ill: (ALUControl[2:1] == 2'b11)};
    assign inReady  = (count_q != 2'd2);
    assign outValid = (count_q != 2'd0);
    assign push     = inValid & inReady & ~flush;
    assign pop      = outValid & outReady & ~flush;

    // push+pop can only coincide at count=1, since push needs count<2 and pop needs count>0
    always_comb begin
        count_d = count_q;
        e0_d    = e0_q;
        e1_d    = e1_q;
        if (flush) begin
            count_d = 2'd0;
        end else if (push && pop) begin
            e0_d = new_e;
        end else if (pop) begin
            e0_d    = e1_q;
            count_d = count_q - 2'd1;
        end else if (push) begin
            if (count_q == 2'd0) e0_d = new_e;
            else e1_d = new_e;
            count_d = count_q + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            e0_q    <= '0;
            e1_q    <= '0;
        end else begin
            count_q <= count_d;
            e0_q    <= e0_d;
            e1_q    <= e1_d;
        end
    end

    assign ALUResult = e0_q.res;
    assign zero      = e0_q.z;
    assign rdOut     = e0_q.rd;
    assign illegalOp = e0_q.ill;

`ifdef ALU_ERR_STICKY_EN
    logic err_q, err_d;

    assign err_d     = (push & new_e.ill) ? 1'b1 : errClr ? 1'b0 : err_q;
    assign errSticky = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_q <= 1'b0;
        else err_q <= err_d;
    end
`endif
endmodule
